// File: rtl/piezo_alert_ctrl.sv
// rtl/piezo_alert_ctrl.sv - alert conditioning (debounce, hysteresis, hold) ahead of the piezo driver
// Define BATT_LATCH_EN to make batt_low sticky until reset.
module piezo_alert_ctrl #(
    parameter logic [11:0] BATT_LOW_TH = 12'h800,
    parameter logic [11:0] BATT_HYST   = 12'h040,
    parameter logic [3:0]  BATT_CNT    = 4'd8,
    parameter logic [10:0] SPD_TH      = 11'd900,
    parameter logic [19:0] OVR_HOLD    = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [11:0] batt,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        en_steer_in,
    output logic        en_steer,
    output logic        ovr_spd,
    output logic        batt_low,
    output logic        steer_en_clr_tmr
);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_LOW_PND = 2'd1,
        ST_LOW     = 2'd2,
        ST_OK_PND  = 2'd3
    } batt_st_e;

    batt_st_e    st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] hold_q, hold_d;
    logic        en_steer_q;
    logic        ovr_q, ovr_d;
    logic        batt_low_q, batt_low_d;
    logic        any_prev_q;
    logic        clr_q, clr_d;
    logic        any_now;
    logic        over_smp;
    logic        batt_is_low;

    // -1024 has no positive 11-bit counterpart, so it saturates to 1023
    function automatic logic [10:0] spd_mag(input logic [10:0] s);
        if (!s[10])
            return s;
        if (s == 11'h400)
            return 11'h3FF;
        return (~s) + 11'd1;
    endfunction

    assign over_smp    = vld & ((spd_mag(lft_spd) > SPD_TH) | (spd_mag(rght_spd) > SPD_TH));
    assign batt_is_low = batt < BATT_LOW_TH;

`ifndef BATT_LATCH_EN
    logic [12:0] ok_th;
    logic        batt_is_ok;
    assign ok_th      = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};
    assign batt_is_ok = {1'b0, batt} >= ok_th;
`endif

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (vld) begin
            case (st_q)
                ST_OK: begin
                    if (batt_is_low) begin
                        if (BATT_CNT <= 4'd1) begin
                            st_d  = ST_LOW;
                            cnt_d = 4'd0;
                        end else begin
                            st_d  = ST_LOW_PND;
                            cnt_d = 4'd1;
                        end
                    end
                end
                ST_LOW_PND: begin
                    if (!batt_is_low) begin
                        st_d  = ST_OK;
                        cnt_d = 4'd0;
                    end else if (cnt_q + 4'd1 >= BATT_CNT) begin
                        st_d  = ST_LOW;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef BATT_LATCH_EN
                ST_LOW: begin
                    st_d  = ST_LOW;
                    cnt_d = 4'd0;
                end
                ST_OK_PND: begin
                    st_d  = ST_LOW;
                    cnt_d = 4'd0;
                end
`else
                ST_LOW: begin
                    if (batt_is_ok) begin
                        if (BATT_CNT <= 4'd1) begin
                            st_d  = ST_OK;
                            cnt_d = 4'd0;
                        end else begin
                            st_d  = ST_OK_PND;
                            cnt_d = 4'd1;
                        end
                    end
                end
                ST_OK_PND: begin
                    if (!batt_is_ok) begin
                        st_d  = ST_LOW;
                        cnt_d = 4'd0;
                    end else if (cnt_q + 4'd1 >= BATT_CNT) begin
                        st_d  = ST_OK;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif
                default: begin
                    st_d  = ST_OK;
                    cnt_d = 4'd0;
                end
            endcase
        end
    end

    assign batt_low_d = (st_d == ST_LOW) | (st_d == ST_OK_PND);

    // ovr_spd follows the pre-decrement count, so it drops one clock after the count hits 0
    assign hold_d = over_smp ? OVR_HOLD : ((hold_q != 20'd0) ? hold_q - 20'd1 : 20'd0);
    assign ovr_d  = over_smp | (hold_q != 20'd0);

    assign any_now = en_steer_q | ovr_q | batt_low_q;
    assign clr_d   = any_prev_q & ~any_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= ST_OK;
            cnt_q      <= 4'd0;
            hold_q     <= 20'd0;
            en_steer_q <= 1'b0;
            ovr_q      <= 1'b0;
            batt_low_q <= 1'b0;
            any_prev_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            en_steer_q <= en_steer_in;
            ovr_q      <= ovr_d;
            batt_low_q <= batt_low_d;
            any_prev_q <= any_now;
            clr_q      <= clr_d;
        end
    end

    assign en_steer         = en_steer_q;
    assign ovr_spd          = ovr_q;
    assign batt_low         = batt_low_q;
    assign steer_en_clr_tmr = clr_q;

endmodule

// File: tb/tb_piezo_alert_ctrl.sv
// tb/tb_piezo_alert_ctrl.sv - randomized and directed bench for piezo_alert_ctrl against a behavioural model
module tb_piezo_alert_ctrl;

    localparam int HOLD   = 40;
    localparam int BATT_N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [11:0] batt;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        en_steer_in;
    logic        en_steer;
    logic        ovr_spd;
    logic        batt_low;
    logic        steer_en_clr_tmr;

    always #5 clk = ~clk;

    piezo_alert_ctrl #(
        .OVR_HOLD(20'(HOLD))
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vld             (vld),
        .batt            (batt),
        .lft_spd         (lft_spd),
        .rght_spd        (rght_spd),
        .en_steer_in     (en_steer_in),
        .en_steer        (en_steer),
        .ovr_spd         (ovr_spd),
        .batt_low        (batt_low),
        .steer_en_clr_tmr(steer_en_clr_tmr)
    );

    int errors = 0;
    int checks = 0;

    bit m_en, m_ovr, m_low, m_clr;
    bit seen;
    int since;
    int run;
    bit hist;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mag(input logic [10:0] s);
        int v;
        v = $signed(s);
        if (v < 0) v = -v;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    task automatic model_edge();
        bit any_prev;
        any_prev = m_en | m_ovr | m_low;
        if (!rst_n) begin
            m_en = 0; m_ovr = 0; m_low = 0; m_clr = 0;
            seen = 0; since = 0; run = 0; hist = 0;
            return;
        end
        m_clr = hist & !any_prev;
        hist  = any_prev;
        m_en  = en_steer_in;
        if (vld && (mag(lft_spd) > 900 || mag(rght_spd) > 900)) begin
            seen  = 1;
            since = 0;
        end else if (seen) begin
            since++;
        end
        m_ovr = seen && (since <= HOLD);
        if (vld) begin
            if (!m_low) begin
                if (batt < 12'h800) run++; else run = 0;
                if (run == BATT_N) begin m_low = 1; run = 0; end
            end else begin
`ifndef BATT_LATCH_EN
                if (batt >= 12'h840) run++; else run = 0;
                if (run == BATT_N) begin m_low = 0; run = 0; end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("en_steer", en_steer, m_en);
        check_eq("ovr_spd", ovr_spd, m_ovr);
        check_eq("batt_low", batt_low, m_low);
        check_eq("clr_tmr", steer_en_clr_tmr, m_clr);
    endtask

    task automatic smp(input logic [11:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            vld  = 1'b1;
            batt = b;
            step();
        end
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic spd_smp(input logic [10:0] l, input logic [10:0] r);
        vld      = 1'b1;
        batt     = 12'hA00;
        lft_spd  = l;
        rght_spd = r;
        step();
        vld      = 1'b0;
        lft_spd  = 11'd0;
        rght_spd = 11'd0;
    endtask

    task automatic count_ovr_tail(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < HOLD + 10; i++) begin
            step();
            if (ovr_spd) hi++;
        end
        check_eq(tag, hi, HOLD);
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b1; batt = 12'd0;
        lft_spd = 11'd0; rght_spd = 11'd0; en_steer_in = 1'b0;

        step();
        step();
        check_eq("rst_batt_low", batt_low, 0);
        check_eq("rst_ovr", ovr_spd, 0);
        check_eq("rst_clr", steer_en_clr_tmr, 0);
        rst_n = 1'b1;
        smp(12'd0, 7);
        check_eq("low_after7", batt_low, 0);
        smp(12'd0, 1);
        check_eq("low_after8", batt_low, 1);

        smp(12'h7FF, 8);
        check_eq("low_7ff", batt_low, 1);
        smp(12'h830, 8);
        check_eq("band_830", batt_low, 1);
        smp(12'h840, 8);
`ifdef BATT_LATCH_EN
        check_eq("recover_840", batt_low, 1);
`else
        check_eq("recover_840", batt_low, 0);
`endif

        rst_n = 1'b0; step(); rst_n = 1'b1;
        smp(12'h100, 7);
        smp(12'h900, 1);
        smp(12'h100, 7);
        check_eq("debounce_break", batt_low, 0);

        idle(3);
        spd_smp(11'h400, 11'd0);
        check_eq("ovr_rise", ovr_spd, 1);
        count_ovr_tail("ovr_hold_len");
        spd_smp(11'd0, 11'd900);
        check_eq("ovr_at_900", ovr_spd, 0);
        spd_smp(11'd0, 11'd901);
        check_eq("ovr_at_901", ovr_spd, 1);
        idle(HOLD + 5);

        for (int k = 0; k < 3; k++) begin
            spd_smp(11'h7FF - 11'd900, 11'd0);
            if (k < 2) idle(HOLD / 2 - 1);
        end
        count_ovr_tail("ovr_reload_len");

        en_steer_in = 1'b1; idle(3);
        en_steer_in = 1'b0; idle(1);
        check_eq("en_fall", en_steer, 0);
        check_eq("clr_same", steer_en_clr_tmr, 0);
        idle(1);
        check_eq("clr_pulse", steer_en_clr_tmr, 1);
        idle(1);
        check_eq("clr_end", steer_en_clr_tmr, 0);

        en_steer_in = 1'b1; idle(2);
        spd_smp(11'd1000, 11'd0);
        en_steer_in = 1'b0; idle(3);
        check_eq("clr_blocked", steer_en_clr_tmr, 0);
        idle(HOLD + 5);

        for (int blk = 0; blk < 200; blk++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 16; c++) begin
                int v;
                vld = ($urandom_range(0, 9) < 7);
                case (mode)
                    0: batt = 12'($urandom_range(0, 12'h7FF));
                    1: batt = 12'($urandom_range(12'h840, 12'hFFF));
                    2: batt = 12'($urandom_range(12'h800, 12'h83F));
                    default: batt = 12'($urandom_range(0, 12'hFFF));
                endcase
                if ($urandom_range(0, 39) == 0) begin
                    lft_spd = 11'($urandom_range(0, 2047));
                end else begin
                    v = int'($urandom_range(0, 1800)) - 900;
                    lft_spd = 11'(v);
                end
                v = int'($urandom_range(0, 1800)) - 900;
                rght_spd = 11'(v);
                if ($urandom_range(0, 19) == 0) en_steer_in = ~en_steer_in;
                rst_n = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
